// File: rtl/wash_sensor_timer.sv
// wash_sensor_timer: debounced level flags, wash/spin timers and fill/drain watchdogs
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   level[7:0]             sampled water level (unsigned)
//   fill_value_on          fill valve command
//   drain_value_on         drain valve command
//   motor_on               wash motor command
//   filled, drained        debounced level flags with hysteresis on release
//   cycle_timeout          motor has run CYCLE_LEN consecutive clocks
//   spin_timeout           draining on an empty tank for SPIN_LEN consecutive clocks
//   fill_fault             sticky: filling for FILL_MAX clocks without reaching full
//   drain_fault            sticky: draining for DRAIN_MAX clocks without reaching empty
// Every output comes straight from a flop, so the controller may feed these back
// through combinational logic without forming a loop.
module wash_sensor_timer #(
  parameter logic [7:0]  FULL_LEVEL  = 8'd200,
  parameter logic [7:0]  EMPTY_LEVEL = 8'd10,
  parameter logic [7:0]  HYST        = 8'd5,
  parameter int          DEBOUNCE    = 3,
  parameter logic [15:0] CYCLE_LEN   = 16'd1000,
  parameter logic [15:0] SPIN_LEN    = 16'd500,
  parameter logic [15:0] FILL_MAX    = 16'd4000,
  parameter logic [15:0] DRAIN_MAX   = 16'd4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       fill_value_on,
  input  logic       drain_value_on,
  input  logic       motor_on,
  output logic       filled,
  output logic       drained,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic       fill_fault,
  output logic       drain_fault
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [0:0] EMPTYISH = 1'b0;
  localparam logic [0:0] FULL     = 1'b1;
  localparam logic [0:0] WETTISH  = 1'b0;
  localparam logic [0:0] EMPTY    = 1'b1;
  logic [0:0]    fill_st, drain_st;
  logic [DW-1:0] fill_db, drain_db;
  logic          fill_hit, drain_hit;
  logic [15:0]   cyc_cnt, spin_cnt, fill_wd, drain_wd;
  logic          spin_run, fill_run, drain_run;
  // A qualifying sample depends on which side of the hysteresis band we are on;
  // anything else (including in-band levels) restarts the debounce count.
  always_comb begin
    fill_hit  = (fill_st == EMPTYISH) ? (level >= FULL_LEVEL) : (level < FULL_LEVEL - HYST);
    drain_hit = (drain_st == WETTISH) ? (level <= EMPTY_LEVEL) : (level > EMPTY_LEVEL + HYST);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_st <= EMPTYISH;
      fill_db <= '0;
    end else if (!fill_hit) begin
      fill_db <= '0;
    end else if (fill_db == DB_LAST) begin
      fill_st <= ~fill_st;
      fill_db <= '0;
    end else begin
      fill_db <= fill_db + DB_ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_st <= WETTISH;
      drain_db <= '0;
    end else if (!drain_hit) begin
      drain_db <= '0;
    end else if (drain_db == DB_LAST) begin
      drain_st <= ~drain_st;
      drain_db <= '0;
    end else begin
      drain_db <= drain_db + DB_ONE;
    end
  end
  assign filled  = (fill_st == FULL);
  assign drained = (drain_st == EMPTY);
  // Spin and watchdogs qualify on the registered flags, i.e. last edge's view of the tank.
  always_comb begin
    spin_run  = drain_value_on && drained;
    fill_run  = fill_value_on && !filled;
    drain_run = drain_value_on && !drained;
  end
  // Timeout is set on the edge the count reaches its limit, so latency from the
  // first qualifying edge is exactly the limit in edges.
  always_ff @(posedge clk) begin
    if (reset || !motor_on) begin
      cyc_cnt       <= '0;
      cycle_timeout <= 1'b0;
    end else begin
      cyc_cnt       <= (cyc_cnt == CYCLE_LEN) ? cyc_cnt : cyc_cnt + 16'd1;
      cycle_timeout <= cycle_timeout || (cyc_cnt == CYCLE_LEN - 16'd1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !spin_run) begin
      spin_cnt     <= '0;
      spin_timeout <= 1'b0;
    end else begin
      spin_cnt     <= (spin_cnt == SPIN_LEN) ? spin_cnt : spin_cnt + 16'd1;
      spin_timeout <= spin_timeout || (spin_cnt == SPIN_LEN - 16'd1);
    end
  end
  // Watchdog counts clear when the condition drops, but the faults stay until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_wd    <= '0;
      fill_fault <= 1'b0;
    end else if (!fill_run) begin
      fill_wd <= '0;
    end else begin
      fill_wd    <= (fill_wd == FILL_MAX) ? fill_wd : fill_wd + 16'd1;
      fill_fault <= fill_fault || (fill_wd == FILL_MAX - 16'd1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_wd    <= '0;
      drain_fault <= 1'b0;
    end else if (!drain_run) begin
      drain_wd <= '0;
    end else begin
      drain_wd    <= (drain_wd == DRAIN_MAX) ? drain_wd : drain_wd + 16'd1;
      drain_fault <= drain_fault || (drain_wd == DRAIN_MAX - 16'd1);
    end
  end
endmodule
